// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl
// Reset/lock supervisor and dynamic-reconfiguration sequencer for the HDMI
// pixel/serial-clock PLL. Runs on the free-running board clock that also
// feeds the PLL reference. It holds the PLL in reset and then waits for a
// qualified lock. Only after that does it enable the output clocks and
// release the video pipeline reset. A mode change, lock loss or lock timeout
// re-runs the sequence. Repeated timeouts end in FAULT.
//
// Ports
//   clk           in   board clock
//   rst           in   asynchronous active-high reset
//   pll_lock      in   PLL LOCK, asynchronous to clk
//   cfg_valid     in   new divider set offered
//   cfg_ready     out  set accepted when cfg_valid && cfg_ready
//   cfg_mdsel     in   requested MDSEL code (7 bits)
//   cfg_odsel0    in   requested ODSEL0 code (7 bits)
//   cfg_odsel1    in   requested ODSEL1 code (7 bits)
//   pll_reset     out  PLL RESET
//   pll_mdsel     out  PLL MDSEL code
//   pll_odsel0    out  PLL ODSEL0 code
//   pll_odsel1    out  PLL ODSEL1 code
//   clk_en        out  PLL ENCLK0/ENCLK1
//   out_rst       out  active-high reset to the video pipeline
//   locked        out  high while running on a qualified lock
//   fault         out  high after the retry budget is exhausted
//   retry_cnt     out  retries consumed in the current sequence
//   lock_loss_cnt out  lock drops seen while running, saturating at 255
//
// MAX_RETRY must fit in the 2-bit retry_cnt port (0..3).

module pll_reconfig_ctrl #(
  parameter int         RST_HOLD_CYCLES     = 16,
  parameter int         LOCK_STABLE_CYCLES  = 1024,
  parameter int         LOCK_TIMEOUT_CYCLES = 50000,
  parameter int         MAX_RETRY           = 3,
  parameter int         OUT_RST_DELAY       = 4,
  parameter logic [6:0] INIT_MDSEL          = 7'd30,
  parameter logic [6:0] INIT_ODSEL0         = 7'd10,
  parameter logic [6:0] INIT_ODSEL1         = 7'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [6:0] cfg_mdsel,
  input  logic [6:0] cfg_odsel0,
  input  logic [6:0] cfg_odsel1,
  output logic       pll_reset,
  output logic [6:0] pll_mdsel,
  output logic [6:0] pll_odsel0,
  output logic [6:0] pll_odsel1,
  output logic       clk_en,
  output logic       out_rst,
  output logic       locked,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int DW = (OUT_RST_DELAY > 0) ? $clog2(OUT_RST_DELAY + 1) : 1;

  // Terminal values are "one before the limit" because the transition
  // happens on the edge that would bring the counter to the limit.
  localparam logic [HW-1:0] HOLD_LAST    = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] DLY_LAST     = DW'((OUT_RST_DELAY > 0) ? OUT_RST_DELAY - 1 : 0);
  localparam logic [1:0]    RETRY_LIMIT  = 2'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT,
    S_RUN,
    S_FAULT
  } state_t;

  state_t          state;
  logic            lock_meta;
  logic            lock_s;
  logic [HW-1:0]   hold_cnt;
  logic [SW-1:0]   stable_cnt;
  logic [TW-1:0]   timeout_cnt;
  logic [DW-1:0]   dly_cnt;

  logic handshake;
  logic go_wait;
  logic go_run;
  logic timed_out;
  logic go_retry;
  logic go_fault;
  logic lost;
  logic go_hold;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // cfg_ready is only high in RUN and FAULT, so a handshake can only happen
  // there. A handshake beats a simultaneous lock drop, so "lost" excludes it.
  // Lock beats timeout when both land on the same WAIT cycle.
  always_comb begin
    handshake = cfg_valid && cfg_ready;
    go_wait   = (state == S_HOLD) && (hold_cnt == HOLD_LAST);
    go_run    = (state == S_WAIT) && lock_s && (stable_cnt == STABLE_LAST);
    timed_out = (state == S_WAIT) && !go_run && (timeout_cnt == TIMEOUT_LAST);
    go_retry  = timed_out && (retry_cnt < RETRY_LIMIT);
    go_fault  = timed_out && !(retry_cnt < RETRY_LIMIT);
    lost      = (state == S_RUN) && !lock_s && !handshake;
    go_hold   = go_retry || handshake || lost;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_HOLD;
      pll_reset     <= 1'b1;
      clk_en        <= 1'b0;
      out_rst       <= 1'b1;
      cfg_ready     <= 1'b0;
      locked        <= 1'b0;
      fault         <= 1'b0;
      hold_cnt      <= '0;
      stable_cnt    <= '0;
      timeout_cnt   <= '0;
      dly_cnt       <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_mdsel     <= INIT_MDSEL;
      pll_odsel0    <= INIT_ODSEL0;
      pll_odsel1    <= INIT_ODSEL1;
    end else begin
      if (go_hold) begin
        state     <= S_HOLD;
        pll_reset <= 1'b1;
        clk_en    <= 1'b0;
        out_rst   <= 1'b1;
        cfg_ready <= 1'b0;
        locked    <= 1'b0;
        fault     <= 1'b0;
      end else if (go_wait) begin
        state     <= S_WAIT;
        pll_reset <= 1'b0;
      end else if (go_run) begin
        state     <= S_RUN;
        clk_en    <= 1'b1;
        locked    <= 1'b1;
        cfg_ready <= 1'b1;
        out_rst   <= (OUT_RST_DELAY > 0);
        dly_cnt   <= '0;
      end else if (go_fault) begin
        state     <= S_FAULT;
        pll_reset <= 1'b1;
        fault     <= 1'b1;
        cfg_ready <= 1'b1;
      end else if ((state == S_RUN) && out_rst) begin
        // Clocks run for OUT_RST_DELAY cycles before the pipeline leaves reset.
        if (dly_cnt == DLY_LAST) begin
          out_rst <= 1'b0;
        end else begin
          dly_cnt <= dly_cnt + DW'(1);
        end
      end

      // Phase counters are zero outside their own state, so they are
      // automatically clear on every state entry.
      if ((state == S_HOLD) && !go_wait) begin
        hold_cnt <= hold_cnt + HW'(1);
      end else begin
        hold_cnt <= '0;
      end

      if ((state == S_WAIT) && !go_run && !timed_out) begin
        stable_cnt  <= lock_s ? stable_cnt + SW'(1) : '0;
        timeout_cnt <= timeout_cnt + TW'(1);
      end else begin
        stable_cnt  <= '0;
        timeout_cnt <= '0;
      end

      if (go_retry) begin
        retry_cnt <= retry_cnt + 2'd1;
      end else if (handshake || lost) begin
        retry_cnt <= '0;
      end

      if (lost && (lock_loss_cnt != 8'hFF)) begin
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
      end

      // Codes only move on the edge that enters HOLD, so the PLL never sees
      // a divider change while it is out of reset.
      if (handshake) begin
        pll_mdsel  <= cfg_mdsel;
        pll_odsel0 <= cfg_odsel0;
        pll_odsel1 <= cfg_odsel1;
      end
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb_pll_reconfig_ctrl
// Randomized bench for pll_reconfig_ctrl. A behavioural model tracks the
// controller phase, the time spent in it and the synchronized lock history.
// Every output is predicted from that model on every cycle. Directed episodes
// cover several cases: first lock, a lock glitch in WAIT, lock timeout into
// FAULT, a reconfiguration, a lock drop, a handshake that collides with a lock
// drop, and an asynchronous reset in the middle of WAIT.

module tb_pll_reconfig_ctrl;

  localparam int HOLD_N    = 4;
  localparam int STABLE_N  = 8;
  localparam int TIMEOUT_N = 32;
  localparam int RETRY_N   = 2;
  localparam int DELAY_N   = 4;

  localparam int M_HOLD  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_RUN   = 2;
  localparam int M_FAULT = 3;

  localparam int LK_NORMAL = 0;
  localparam int LK_GLITCH = 1;
  localparam int LK_NEVER  = 2;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [6:0] cfg_mdsel;
  logic [6:0] cfg_odsel0;
  logic [6:0] cfg_odsel1;
  logic       pll_reset;
  logic [6:0] pll_mdsel;
  logic [6:0] pll_odsel0;
  logic [6:0] pll_odsel1;
  logic       clk_en;
  logic       out_rst;
  logic       locked;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  pll_reconfig_ctrl #(
    .RST_HOLD_CYCLES    (HOLD_N),
    .LOCK_STABLE_CYCLES (STABLE_N),
    .LOCK_TIMEOUT_CYCLES(TIMEOUT_N),
    .MAX_RETRY          (RETRY_N),
    .OUT_RST_DELAY      (DELAY_N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_lock     (pll_lock),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_mdsel    (cfg_mdsel),
    .cfg_odsel0   (cfg_odsel0),
    .cfg_odsel1   (cfg_odsel1),
    .pll_reset    (pll_reset),
    .pll_mdsel    (pll_mdsel),
    .pll_odsel0   (pll_odsel0),
    .pll_odsel1   (pll_odsel1),
    .clk_en       (clk_en),
    .out_rst      (out_rst),
    .locked       (locked),
    .fault        (fault),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int         m_mode;
  int         m_age;
  int         m_run_len;
  int         m_retry;
  int         m_loss;
  logic [6:0] m_md, m_o0, m_o1;
  logic       m_hist0, m_hist1;

  // Stimulus control
  int         lk_policy;
  int         lk_delay;
  int         since_rel;
  int         drop_left;
  int         cv_cycles;
  bit         collide_arm;
  logic [6:0] req_md, req_o0, req_o1;

  // Observation bookkeeping
  int   cyc;
  int   wait_entry_cyc;
  int   locked_cyc;
  logic prev_pll_reset;
  logic prev_locked;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode    = M_HOLD;
    m_age     = 0;
    m_run_len = 0;
    m_retry   = 0;
    m_loss    = 0;
    m_md      = 7'd30;
    m_o0      = 7'd10;
    m_o1      = 7'd2;
    m_hist0   = 1'b0;
    m_hist1   = 1'b0;
  endtask

  // One clock edge of the controller's behaviour, from the rules directly.
  task automatic model_edge(input logic lk, input logic cv,
                            input logic [6:0] cm, input logic [6:0] c0, input logic [6:0] c1);
    logic ls;
    bit   hs;
    ls = m_hist1;
    hs = cv && (m_mode == M_RUN || m_mode == M_FAULT);
    case (m_mode)
      M_HOLD: begin
        m_age++;
        if (m_age == HOLD_N) begin
          m_mode = M_WAIT; m_age = 0; m_run_len = 0;
        end
      end
      M_WAIT: begin
        m_age++;
        m_run_len = ls ? m_run_len + 1 : 0;
        if (m_run_len == STABLE_N) begin
          m_mode = M_RUN; m_age = 0;
        end else if (m_age == TIMEOUT_N) begin
          m_age = 0;
          if (m_retry < RETRY_N) begin
            m_retry++; m_mode = M_HOLD;
          end else begin
            m_mode = M_FAULT;
          end
        end
      end
      M_RUN: begin
        if (hs) begin
          m_md = cm; m_o0 = c0; m_o1 = c1;
          m_mode = M_HOLD; m_age = 0; m_retry = 0;
        end else if (!ls) begin
          m_mode = M_HOLD; m_age = 0; m_retry = 0;
          if (m_loss < 255) m_loss++;
        end else begin
          m_age++;
        end
      end
      default: begin
        if (hs) begin
          m_md = cm; m_o0 = c0; m_o1 = c1;
          m_mode = M_HOLD; m_age = 0; m_retry = 0;
        end
      end
    endcase
    m_hist1 = m_hist0;
    m_hist0 = lk;
  endtask

  task automatic compare_all();
    checkOutput("pll_reset", pll_reset, (m_mode == M_HOLD || m_mode == M_FAULT));
    checkOutput("clk_en", clk_en, (m_mode == M_RUN));
    checkOutput("out_rst", out_rst, !(m_mode == M_RUN && m_age >= DELAY_N));
    checkOutput("locked", locked, (m_mode == M_RUN));
    checkOutput("fault", fault, (m_mode == M_FAULT));
    checkOutput("cfg_ready", cfg_ready, (m_mode == M_RUN || m_mode == M_FAULT));
    checkOutput("retry_cnt", retry_cnt, m_retry);
    checkOutput("lock_loss_cnt", lock_loss_cnt, m_loss);
    checkOutput("codes", {pll_mdsel, pll_odsel0, pll_odsel1}, {m_md, m_o0, m_o1});
  endtask

  // Drives the PLL lock behaviour and the configuration port for the next edge.
  task automatic applyStimulus();
    logic lk;
    if (m_mode == M_WAIT || m_mode == M_RUN) since_rel++;
    else since_rel = 0;
    case (lk_policy)
      LK_NORMAL: lk = (since_rel > lk_delay);
      LK_GLITCH: lk = (since_rel > lk_delay) && (since_rel != lk_delay + 6);
      default:   lk = 1'b0;
    endcase
    if (drop_left > 0) begin
      lk = 1'b0;
      drop_left--;
    end
    pll_lock = lk;
    if (collide_arm && m_mode == M_RUN && m_hist1 == 1'b0) begin
      cv_cycles   = 1;
      collide_arm = 1'b0;
    end
    if (cv_cycles > 0) begin
      cfg_valid  = 1'b1;
      cfg_mdsel  = req_md;
      cfg_odsel0 = req_o0;
      cfg_odsel1 = req_o1;
      cv_cycles--;
    end else begin
      cfg_valid  = 1'b0;
      cfg_mdsel  = 7'($urandom_range(0, 127));
      cfg_odsel0 = 7'($urandom_range(0, 127));
      cfg_odsel1 = 7'($urandom_range(0, 127));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(pll_lock, cfg_valid, cfg_mdsel, cfg_odsel0, cfg_odsel1);
    #1;
    cyc++;
    if (prev_pll_reset === 1'b1 && pll_reset === 1'b0) wait_entry_cyc = cyc;
    if (prev_locked === 1'b0 && locked === 1'b1) locked_cyc = cyc;
    prev_pll_reset = pll_reset;
    prev_locked    = locked;
    compare_all();
    applyStimulus();
  endtask

  // sel: 0 locked, 1 fault, 2 pll_reset high, 3 pll_reset low, 4 out_rst high, 5 fault low
  task automatic wait_for(input int sel, input int budget, input string tag, output int n);
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      cycle();
      n++;
      case (sel)
        0:       hit = (locked === 1'b1);
        1:       hit = (fault === 1'b1);
        2:       hit = (pll_reset === 1'b1);
        3:       hit = (pll_reset === 1'b0);
        4:       hit = (out_rst === 1'b1);
        default: hit = (fault === 1'b0);
      endcase
    end
    checkOutput({tag, "_reached"}, hit, 1'b1);
  endtask

  task automatic request_cfg(input logic [6:0] md, input logic [6:0] o0, input logic [6:0] o1, input int hold);
    req_md    = md;
    req_o0    = o0;
    req_o1    = o1;
    cv_cycles = hold;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_pll_reset"}, pll_reset, 1'b1);
    checkOutput({tag, "_clk_en"}, clk_en, 1'b0);
    checkOutput({tag, "_out_rst"}, out_rst, 1'b1);
    checkOutput({tag, "_cfg_ready"}, cfg_ready, 1'b0);
    checkOutput({tag, "_locked"}, locked, 1'b0);
    checkOutput({tag, "_fault"}, fault, 1'b0);
    checkOutput({tag, "_retry"}, retry_cnt, 0);
    checkOutput({tag, "_loss"}, lock_loss_cnt, 0);
    checkOutput({tag, "_codes"}, {pll_mdsel, pll_odsel0, pll_odsel1}, {7'd30, 7'd10, 7'd2});
  endtask

  task automatic release_reset();
    model_reset();
    pll_lock    = 1'b0;
    cfg_valid   = 1'b0;
    cv_cycles   = 0;
    drop_left   = 0;
    collide_arm = 1'b0;
    since_rel   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst            = 1'b0;
    prev_pll_reset = 1'b1;
    prev_locked    = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int loss_before;
    logic [6:0] rm, r0, r1;

    rst        = 1'b1;
    pll_lock   = 1'b0;
    cfg_valid  = 1'b0;
    cfg_mdsel  = '0;
    cfg_odsel0 = '0;
    cfg_odsel1 = '0;
    lk_policy  = LK_NORMAL;
    lk_delay   = 10;
    cyc        = 0;
    wait_entry_cyc = 0;
    locked_cyc     = 0;

    @(posedge clk);
    #1;
    check_reset_values("por");
    release_reset();

    // First lock: lock 10 cycles after pll_reset falls -> RUN 20 cycles after WAIT entry
    wait_for(0, 200, "first_lock", n);
    checkOutput("first_lock_latency", locked_cyc - wait_entry_cyc, 20);
    repeat (DELAY_N) cycle();
    checkOutput("first_out_rst_low", out_rst, 1'b0);
    checkOutput("first_codes", {pll_mdsel, pll_odsel0, pll_odsel1}, {7'd30, 7'd10, 7'd2});

    // Lock glitch during WAIT restarts qualification
    lk_policy = LK_GLITCH;
    request_cfg(7'd33, 7'd11, 7'd3, 1);
    wait_for(2, 10, "glitch_hold", n);
    wait_for(0, 200, "glitch_lock", n);
    checkOutput("glitch_lock_latency", locked_cyc - wait_entry_cyc, 26);
    checkOutput("glitch_retry", retry_cnt, 0);
    lk_policy = LK_NORMAL;

    // Lock never comes: retries exhaust into FAULT, a handshake recovers
    lk_policy = LK_NEVER;
    wait_for(1, 400, "fault", n);
    checkOutput("fault_retry", retry_cnt, 2);
    checkOutput("fault_pll_reset", pll_reset, 1'b1);
    checkOutput("fault_cfg_ready", cfg_ready, 1'b1);
    repeat (5) cycle();
    lk_policy = LK_NORMAL;
    lk_delay  = int'($urandom_range(0, 18));
    rm = 7'($urandom_range(0, 127));
    r0 = 7'($urandom_range(0, 127));
    r1 = 7'($urandom_range(0, 127));
    request_cfg(rm, r0, r1, 1);
    wait_for(5, 10, "fault_exit", n);
    checkOutput("fault_exit_retry", retry_cnt, 0);
    checkOutput("fault_exit_codes", {pll_mdsel, pll_odsel0, pll_odsel1}, {rm, r0, r1});
    wait_for(0, 200, "fault_relock", n);

    // Reconfiguration in RUN with cfg_valid held through HOLD/WAIT
    repeat (6) cycle();
    request_cfg(7'd40, 7'd8, 7'd4, 14);
    wait_for(2, 10, "reconf_hold", n);
    checkOutput("reconf_codes", {pll_mdsel, pll_odsel0, pll_odsel1}, {7'd40, 7'd8, 7'd4});
    checkOutput("reconf_clk_en", clk_en, 1'b0);
    checkOutput("reconf_out_rst", out_rst, 1'b1);
    checkOutput("reconf_cfg_ready", cfg_ready, 1'b0);
    wait_for(0, 200, "reconf_relock", n);

    // One-cycle lock drop in RUN
    repeat (8) cycle();
    loss_before = m_loss;
    drop_left = 1;
    cycle();
    wait_for(4, 10, "drop_out_rst", n);
    checkOutput("drop_latency_le3", (n <= 3), 1'b1);
    checkOutput("drop_loss_cnt", lock_loss_cnt, loss_before + 1);
    wait_for(0, 200, "drop_relock", n);

    // Handshake on the same edge that sees lock low
    repeat (8) cycle();
    loss_before = m_loss;
    req_md = 7'($urandom_range(0, 127));
    req_o0 = 7'($urandom_range(0, 127));
    req_o1 = 7'($urandom_range(0, 127));
    rm = req_md; r0 = req_o0; r1 = req_o1;
    collide_arm = 1'b1;
    drop_left   = 3;
    wait_for(2, 10, "collide_hold", n);
    checkOutput("collide_loss_cnt", lock_loss_cnt, loss_before);
    checkOutput("collide_codes", {pll_mdsel, pll_odsel0, pll_odsel1}, {rm, r0, r1});
    wait_for(0, 200, "collide_relock", n);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        lk_policy = ($urandom_range(0, 3) == 0) ? LK_NEVER : LK_NORMAL;
        lk_delay  = int'($urandom_range(0, 18));
      end
      if (lk_policy == LK_NEVER && $urandom_range(0, 399) == 0) lk_policy = LK_NORMAL;
      if (m_mode == M_RUN && drop_left == 0 && $urandom_range(0, 79) == 0)
        drop_left = int'($urandom_range(1, 3));
      if (cv_cycles == 0 && $urandom_range(0, 59) == 0)
        request_cfg(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                    7'($urandom_range(0, 127)), int'($urandom_range(1, 5)));
      if (m_mode == M_RUN && !collide_arm && drop_left == 0 && $urandom_range(0, 199) == 0) begin
        req_md = 7'($urandom_range(0, 127));
        req_o0 = 7'($urandom_range(0, 127));
        req_o1 = 7'($urandom_range(0, 127));
        collide_arm = 1'b1;
        drop_left   = 3;
      end
      cycle();
    end

    // Asynchronous reset in the middle of WAIT after a reconfig to 40/8/4
    lk_policy   = LK_NORMAL;
    lk_delay    = 12;
    collide_arm = 1'b0;
    drop_left   = 0;
    if (m_mode == M_FAULT) begin
      request_cfg(7'd40, 7'd8, 7'd4, 1);
      wait_for(5, 10, "pre_rst_fault_exit", n);
    end
    wait_for(0, 400, "pre_rst_lock", n);
    request_cfg(7'd40, 7'd8, 7'd4, 1);
    wait_for(2, 10, "pre_rst_hold", n);
    wait_for(3, 10, "pre_rst_wait", n);
    repeat (3) cycle();
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    release_reset();
    wait_for(0, 200, "post_rst_lock", n);
    repeat (10) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
